// File: rtl/decode_scoreboard.sv
// Register-hazard scoreboard for the decode stage: per-register pending-write counters, a global
// in-flight count, and the combinational issue/stall decision that uses them.
module decode_scoreboard #(
  parameter int unsigned CNT_W        = 2,
  parameter int unsigned MAX_INFLIGHT = 8,
  parameter int unsigned INFL_W       = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              issue_valid_i,
  input  logic              issue_rs1_en_i,
  input  logic              issue_rs2_en_i,
  input  logic [4:0]        issue_rs1_i,
  input  logic [4:0]        issue_rs2_i,
  input  logic              issue_rd_en_i,
  input  logic [4:0]        issue_rd_i,
  input  logic              exec_ready_i,
  input  logic              wb_valid_i,
  input  logic [4:0]        wb_rd_i,
  input  logic              flush_i,
  output logic              issue_fire_o,
  output logic              stall_o,
  output logic [31:0]       busy_o,
  output logic [INFL_W-1:0] inflight_o,
  output logic              err_o
);

  localparam logic [CNT_W-1:0]  CntMax  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CntOne  = CNT_W'(1);
  localparam logic [INFL_W-1:0] InflMax = INFL_W'(MAX_INFLIGHT);

  logic [CNT_W-1:0]  cnt_q [32];
  logic [CNT_W-1:0]  cnt_d [32];
  logic [INFL_W-1:0] inflight_q, inflight_d;
  logic              err_q, err_d;

  logic wb_hit, wb_dec, wb_bad;
  logic rs1_pend, rs2_pend;
  logic raw, waw_sat, full, stall, fire, alloc;

  // Retire decision: only a nonzero counter on a real register is decremented.
  always_comb begin
    wb_hit = wb_valid_i && (wb_rd_i != 5'd0);
    wb_dec = wb_hit && (cnt_q[wb_rd_i] != '0);
    wb_bad = wb_hit && (cnt_q[wb_rd_i] == '0);
  end

  // Hazard check sees this cycle's retire, since the register file writes before it reads.
  always_comb begin
    rs1_pend = (cnt_q[issue_rs1_i] != '0) &&
               !(wb_dec && (wb_rd_i == issue_rs1_i) && (cnt_q[issue_rs1_i] == CntOne));
    rs2_pend = (cnt_q[issue_rs2_i] != '0) &&
               !(wb_dec && (wb_rd_i == issue_rs2_i) && (cnt_q[issue_rs2_i] == CntOne));
    raw      = (issue_rs1_en_i && (issue_rs1_i != 5'd0) && rs1_pend) ||
               (issue_rs2_en_i && (issue_rs2_i != 5'd0) && rs2_pend);
    waw_sat  = issue_rd_en_i && (issue_rd_i != 5'd0) && (cnt_q[issue_rd_i] == CntMax) &&
               !(wb_dec && (wb_rd_i == issue_rd_i));
    full     = issue_rd_en_i && (issue_rd_i != 5'd0) && (inflight_q == InflMax) && !wb_dec;
    stall    = issue_valid_i && !flush_i && (raw || waw_sat || full || !exec_ready_i);
    fire     = issue_valid_i && !flush_i && !stall;
    alloc    = fire && issue_rd_en_i && (issue_rd_i != 5'd0);
  end

  assign stall_o      = stall;
  assign issue_fire_o = fire;

  always_comb begin
    for (int r = 0; r < 32; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r != 0 && !flush_i) begin
        if (alloc && (issue_rd_i == 5'(r)) && !(wb_dec && (wb_rd_i == 5'(r)))) begin
          cnt_d[r] = cnt_q[r] + CntOne;
        end else if (wb_dec && (wb_rd_i == 5'(r)) && !(alloc && (issue_rd_i == 5'(r)))) begin
          cnt_d[r] = cnt_q[r] - CntOne;
        end
      end
      if (r == 0 || flush_i) begin
        cnt_d[r] = '0;
      end
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (flush_i) begin
      inflight_d = '0;
    end else if (alloc && !wb_dec) begin
      inflight_d = inflight_q + INFL_W'(1);
    end else if (wb_dec && !alloc) begin
      inflight_d = inflight_q - INFL_W'(1);
    end
    // Sticky; a flush squashes write-back so it cannot raise the flag that cycle.
    err_d = err_q | (wb_bad && !flush_i);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= '0;
      end
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    busy_o = '0;
    for (int r = 1; r < 32; r++) begin
      busy_o[r] = (cnt_q[r] != '0);
    end
  end

  assign inflight_o = inflight_q;
  assign err_o      = err_q;

endmodule
